// File: rtl/weight_load_ctrl.sv
// Load/drain sequencer for the per-column weight shift buffer.
// Fills DEPTH rows over valid/ready, then drains them into the array on start.
module weight_load_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            start,
    input  logic            abort,
    input  logic            out_stall,
    output logic            load_en,
    output logic            out_en,
    output logic [CNTW-1:0] row_idx,
    output logic            loaded,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] LAST = CNTW'(DEPTH - 1);
    localparam logic [CNTW-1:0] ONE  = CNTW'(1);

    state_t          state, state_n;
    logic [CNTW-1:0] count, count_n;
    logic            done_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            done  <= done_n;
        end
    end

    // Handshake enables stay combinational; rst gating keeps them low in reset
    always_comb begin
        in_ready = rst & ((state == IDLE) | (state == LOAD));
        load_en  = in_valid & in_ready;
        out_en   = rst & (state == DRAIN) & ~out_stall;
        loaded   = (state == FULL);
        busy     = ((state == LOAD) & (count != '0))
                 | (state == FULL)
                 | (state == DRAIN);
        row_idx  = count;
    end

    always_comb begin
        state_n = state;
        count_n = count;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_en) begin
                    state_n = LOAD;
                    count_n = ONE;
                end
            end
            LOAD: begin
                if (load_en) begin
                    if (count == LAST) begin
                        state_n = FULL;
                        count_n = '0;
                    end else begin
                        count_n = count + ONE;
                    end
                end
            end
            FULL: begin
                if (start) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (out_en) begin
                    if (count == LAST) begin
                        state_n = IDLE;
                        count_n = '0;
                        done_n  = 1'b1;
                    end else begin
                        count_n = count + ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
        if (abort) begin
            state_n = IDLE;
            count_n = '0;
            done_n  = 1'b0;
        end
    end

endmodule
